ntt_input_loader: RTL and testbench
===================================

// Module: ntt_input_loader
// PURPOSE
//  Streams N polynomial coefficients from the host into the four 128-deep NTT data banks before a transform.
//  Reduces each coefficient once mod Q and packs every 4 consecutive coefficients into one bank-parallel write.
//  Applies the digit-sum conflict-free bank map, so the NTT stage can read the banks without conflicts.
//  Sits upstream of the NTT core. It owns the bank write ports while busy=1; the core must not start until load_done.
// PARAMETERS
//  DATA_WIDTH  14   coefficient width
//  ADDR_WIDTH  7    per-bank address width (N/4 = 128 words)
//  N           512  coefficients per polynomial
//  MODQ        12289  modulus; inputs are < 2^DATA_WIDTH < 2*MODQ
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   one-cycle pulse; begins a load (ignored unless IDLE)
//  din        in   14  coefficient, natural order index 0..N-1
//  din_valid  in   1   din is valid
//  din_ready  out  1   loader accepts din this cycle
//  wr_en      out  1   write strobe, common to all four banks
//  wr_addr    out  7   bank word address (the same for all banks)
//  wr_data_0..wr_data_3  out  14 each  data for bank 0..3
//  busy       out  1   high in LOAD and FLUSH
//  load_done  out  1   one-cycle pulse when all N words are written
// BEHAVIOUR
//  Reset: state=IDLE, count=0. All outputs are 0: din_ready, wr_en, wr_addr, wr_data_*, busy, load_done.
//  Reset mid-load abandons the load; already-written bank words are don't-care.
//  Handshake: a transfer occurs when din_valid & din_ready. In LOAD, din_ready=1 every cycle (no back-pressure).
//  Reduction: r = (din >= MODQ) ? din - MODQ : din. Computed combinationally on acceptance.
//  count[8:0] = index of the next coefficient to accept. Group index g = count[8:2]; lane j = count[1:0].
//  Lanes 0..2: r is stored in a 3-entry group register.
//  Lane 3: the three stored values plus r are latched into the write registers.
//    The next cycle: wr_en=1, wr_addr=g.
//  Bank map: s = (g[6] + g[5:4] + g[3:2] + g[1:0]) mod 4. Lane j goes to bank (j + s) mod 4.
//    Example: g=1 gives s=1, so lane0->bank1, lane1->bank2, lane2->bank3, lane3->bank0.
//  wr_en is high for exactly one cycle per group. The write registers hold their value when wr_en=0.
//  The group register refills while a write is pending, so there is no stall.
//  FSM:
//    IDLE  -(start)-> LOAD (count=0)
//    LOAD  -(transfer with count==N-1)-> FLUSH. din_ready=0 from FLUSH onward.
//    FLUSH (final wr_en cycle) -> DONE
//    DONE  (load_done=1 for 1 cycle) -> IDLE
//  start is ignored in LOAD, FLUSH and DONE.
//  A gap in din_valid pauses the load only; the partial group is kept.
//  Latency: wr_en follows the 4th coefficient of a group by 1 cycle.
//    load_done follows the final transfer by 2 cycles.
//  Wrap: count wraps 511 -> 0 on the final transfer.
//  start while in IDLE with din_valid=1: the first transfer is the cycle after start.
// STRUCTURE
//  Shared package ntt_pkg: DATA_WIDTH, ADDR_WIDTH, N, MODQ, and the FSM state encoding (IDLE, LOAD, FLUSH, DONE).
//  One sub-module: ntt_bank_map (combinational). Takes g and returns s and the lane->bank permutation.
//    The NTT-side memory map reuses it so both sides agree on placement.
// TESTING
//  1. Reset then start; stream din=i for i=0..511 back-to-back.
//     -> 128 wr_en pulses; g=0 gives wr_data_0..3 = 0,1,2,3; load_done 2 cycles after the last transfer.
//  2. Group g=5 (s=2) carrying 20..23. -> bank2=20, bank3=21, bank0=22, bank1=23, wr_addr=5.
//  3. Reduction: din=12289 -> 0; 12288 -> 12288; 16383 -> 4094.
//  4. din_valid toggled 1/0 every cycle. -> same bank contents as test 1; exactly 128 wr_en pulses; no lost or duplicated words.
//  5. Assert rst at count=200, then reload with a fresh start.
//     -> all outputs 0 during reset; the second load completes normally.
//  6. start pulsed during LOAD and DONE -> ignored; count is not disturbed; only one load_done.

Source files
------------

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT constants, loader FSM encoding and mod-Q helper
package ntt_pkg;

  localparam int DATA_WIDTH = 14;
  localparam int ADDR_WIDTH = 7;
  localparam int N          = 512;
  localparam int MODQ       = 12289;
  localparam int CNT_WIDTH  = $clog2(N);
  localparam int LANES      = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } state_t;

  // Inputs are below 2*MODQ, so one conditional subtraction fully reduces them.
  function automatic logic [DATA_WIDTH-1:0] reduce_q(input logic [DATA_WIDTH-1:0] x);
    return (x >= DATA_WIDTH'(MODQ)) ? x - DATA_WIDTH'(MODQ) : x;
  endfunction

endpackage

// File: rtl/ntt_bank_map.sv
// rtl/ntt_bank_map.sv - digit-sum conflict-free bank map, shared by loader and NTT side
module ntt_bank_map
  import ntt_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] g,
  output logic [1:0]            s,
  output logic [LANES-1:0][1:0] lane_bank
);

  // 2-bit adds wrap, giving the base-4 digit sum mod 4 directly.
  always_comb begin
    s = {1'b0, g[6]} + g[5:4] + g[3:2] + g[1:0];
    for (int j = 0; j < LANES; j++) begin
      lane_bank[j] = 2'(j) + s;
    end
  end

endmodule

// File: rtl/ntt_input_loader.sv
// rtl/ntt_input_loader.sv - streams N coefficients, reduces mod Q, packs groups of 4 into the banks
module ntt_input_loader
  import ntt_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data_0,
  output logic [DATA_WIDTH-1:0] wr_data_1,
  output logic [DATA_WIDTH-1:0] wr_data_2,
  output logic [DATA_WIDTH-1:0] wr_data_3,
  output logic                  busy,
  output logic                  load_done
);

  state_t                 state;
  logic [CNT_WIDTH-1:0]   count;
  logic [DATA_WIDTH-1:0]  grp       [3];
  logic [DATA_WIDTH-1:0]  wr_data_q [LANES];
  logic [DATA_WIDTH-1:0]  lane_val  [LANES];
  logic [DATA_WIDTH-1:0]  bank_data [LANES];
  logic [DATA_WIDTH-1:0]  r;
  logic [ADDR_WIDTH-1:0]  g;
  logic [1:0]             lane;
  logic [1:0]             s;
  logic [LANES-1:0][1:0]  lane_bank;
  logic                   xfer;

  assign xfer = din_valid & din_ready;
  assign r    = reduce_q(din);
  assign g    = count[CNT_WIDTH-1:2];
  assign lane = count[1:0];

  ntt_bank_map u_bank_map (
    .g         (g),
    .s         (s),
    .lane_bank (lane_bank)
  );

  always_comb begin
    lane_val[0] = grp[0];
    lane_val[1] = grp[1];
    lane_val[2] = grp[2];
    lane_val[3] = r;
    bank_data   = '{default: '0};
    for (int j = 0; j < LANES; j++) begin
      bank_data[lane_bank[j]] = lane_val[j];
    end
    assert (lane_bank[0] == s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      din_ready <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      grp       <= '{default: '0};
      wr_data_q <= '{default: '0};
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            count     <= '0;
            din_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            count <= count + 1'b1;
            unique case (lane)
              2'd0:    grp[0] <= r;
              2'd1:    grp[1] <= r;
              2'd2:    grp[2] <= r;
              default: begin
                wr_en     <= 1'b1;
                wr_addr   <= g;
                wr_data_q <= bank_data;
              end
            endcase
            // Last coefficient: count wraps to 0 and the final group drains in FLUSH.
            if (count == CNT_WIDTH'(N - 1)) begin
              state     <= FLUSH;
              din_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state     <= DONE;
          busy      <= 1'b0;
          load_done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_data_0 = wr_data_q[0];
  assign wr_data_1 = wr_data_q[1];
  assign wr_data_2 = wr_data_q[2];
  assign wr_data_3 = wr_data_q[3];

endmodule

// File: tb/tb_ntt_input_loader.sv
// tb/tb_ntt_input_loader.sv - randomized self-checking bench for ntt_input_loader
module tb_ntt_input_loader;

  localparam int NC = 512;
  localparam int Q  = 12289;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [13:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready, wr_en, busy, load_done;
  logic [6:0]  wr_addr;
  logic [13:0] wr_data_0, wr_data_1, wr_data_2, wr_data_3;

  ntt_input_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data_0 (wr_data_0),
    .wr_data_1 (wr_data_1),
    .wr_data_2 (wr_data_2),
    .wr_data_3 (wr_data_3),
    .busy      (busy),
    .load_done (load_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 loading, 2 final write, 3 done pulse.
  int m_phase = 0;
  int m_idx   = 0;
  int m_acc [4];
  int m_data[4];
  int m_wr    = 0;
  int m_addr  = 0;
  int m_g, m_s;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_idx   = 0;
      m_wr    = 0;
      m_addr  = 0;
      for (int b = 0; b < 4; b++) begin
        m_data[b] = 0;
        m_acc[b]  = 0;
      end
    end else begin
      m_wr = 0;
      case (m_phase)
        0: if (start) m_phase = 1;
        1: begin
          if (din_valid) begin
            m_acc[m_idx % 4] = int'(din) % Q;
            m_idx++;
            if (m_idx % 4 == 0) begin
              m_g    = m_idx / 4 - 1;
              m_s    = (m_g / 64 + (m_g / 16) % 4 + (m_g / 4) % 4 + m_g % 4) % 4;
              m_wr   = 1;
              m_addr = m_g;
              for (int j = 0; j < 4; j++) m_data[(j + m_s) % 4] = m_acc[j];
            end
            if (m_idx == NC) begin
              m_idx   = 0;
              m_phase = 2;
            end
          end
        end
        2: m_phase = 3;
        default: m_phase = 0;
      endcase
    end
  end

  int wr_cnt = 0;
  int ld_cnt = 0;
  int cap [128][4];

  always @(negedge clk) begin
    check("din_ready", int'(din_ready), int'(m_phase == 1));
    check("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
    check("load_done", int'(load_done), int'(m_phase == 3));
    check("wr_en", int'(wr_en), m_wr);
    if (m_wr != 0) check("wr_addr", int'(wr_addr), m_addr);
    check("wr_data_0", int'(wr_data_0), m_data[0]);
    check("wr_data_1", int'(wr_data_1), m_data[1]);
    check("wr_data_2", int'(wr_data_2), m_data[2]);
    check("wr_data_3", int'(wr_data_3), m_data[3]);
    if (wr_en) begin
      wr_cnt++;
      cap[wr_addr][0] = int'(wr_data_0);
      cap[wr_addr][1] = int'(wr_data_1);
      cap[wr_addr][2] = int'(wr_data_2);
      cap[wr_addr][3] = int'(wr_data_3);
    end
    if (load_done) ld_cnt++;
  end

  int vals[NC];

  task automatic fill(input int kind);
    for (int i = 0; i < NC; i++) vals[i] = (kind == 0) ? i : int'($urandom_range(0, 16383));
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles each cycle, 2: random gaps.
  task automatic stream(input int mode, input int stop_at, input int poke);
    int k = 0;
    int cyc = 0;
    bit acc;
    while (k < stop_at && cyc < 4000) begin
      case (mode)
        0:       din_valid = 1'b1;
        1:       din_valid = (cyc % 2 == 0);
        default: din_valid = ($urandom_range(0, 3) != 0);
      endcase
      din   = din_valid ? 14'(vals[k]) : 14'($urandom);
      start = (poke != 0 && k == 100);
      @(negedge clk);
      acc = din_valid && din_ready;
      @(posedge clk);
      if (acc) k++;
      cyc++;
      #1;
    end
    din_valid = 1'b0;
    start     = 1'b0;
    if (cyc >= 4000) check("stream_timeout", k, stop_at);
  endtask

  task automatic wait_done(input int poke);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (load_done) begin
        seen = 1;
        if (poke != 0) start = 1'b1;
      end
    end
    check("load_done_seen", int'(seen), 1);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic full_load(input int mode, input int poke);
    wr_cnt = 0;
    ld_cnt = 0;
    do_start();
    stream(mode, NC, poke);
    wait_done(poke);
    repeat (20) @(posedge clk);
    #1;
    check("wr_pulses", wr_cnt, 128);
    check("load_done_count", ld_cnt, 1);
  endtask

  task automatic check_group(input string name, input int g, input int b0, input int b1,
                             input int b2, input int b3);
    check({name, "_bank0"}, cap[g][0], b0);
    check({name, "_bank1"}, cap[g][1], b1);
    check({name, "_bank2"}, cap[g][2], b2);
    check({name, "_bank3"}, cap[g][3], b3);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_din_ready"}, int'(din_ready), 0);
    check({name, "_wr_en"}, int'(wr_en), 0);
    check({name, "_wr_addr"}, int'(wr_addr), 0);
    check({name, "_wr_data"}, int'(wr_data_0 | wr_data_1 | wr_data_2 | wr_data_3), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_load_done"}, int'(load_done), 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Natural-order ramp, back-to-back.
    fill(0);
    full_load(0, 0);
    check_group("ramp_g0", 0, 0, 1, 2, 3);
    check_group("ramp_g5", 5, 22, 23, 20, 21);
    check_group("ramp_g127", 127, 510, 511, 508, 509);

    // Reduction corners, random gaps, start poked in LOAD and DONE.
    fill(0);
    vals[0] = 12289;
    vals[1] = 12288;
    vals[2] = 16383;
    vals[3] = 5;
    full_load(2, 1);
    check_group("reduce_g0", 0, 0, 12288, 4094, 5);

    // Valid toggling every cycle.
    fill(0);
    full_load(1, 0);
    check_group("toggle_g0", 0, 0, 1, 2, 3);
    check_group("toggle_g5", 5, 22, 23, 20, 21);

    // Reset in the middle of a load, then a fresh load.
    fill(1);
    do_start();
    stream(0, 200, 0);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    @(posedge clk);
    #1 rst = 1'b0;
    full_load(2, 0);

    // Random data, back-to-back.
    fill(1);
    full_load(0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
